// File: rtl/scan_display_ctrl.sv
// Enabled BCD up/down counter driving a multiplexed active-low 7-segment display.
// Define SCAN_DISPLAY_LZ_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module scan_display_ctrl #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 100000,
  parameter int TICK_DIV = 100000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [DIGITS-1:0]     seg_an,
  output logic [7:0]            seg_cat
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0]            tick_cnt_q;
  logic [SW-1:0]            scan_cnt_q;
  logic [IW-1:0]            idx_q;
  logic [DIGITS-1:0][3:0]   count_q, count_d;
  logic                     wrap_q;
  logic [DIGITS-1:0]        seg_an_q;
  logic [7:0]               seg_cat_q;
  logic                     carry;
  logic [DIGITS-1:0]        blank;
  logic [3:0]               cur_dig;
  logic [6:0]               cur_seg;
  logic                     tick;

  assign tick      = en && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign seg_an    = seg_an_q;
  assign seg_cat   = seg_cat_q;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Ripple carry/borrow; a carry out of the top digit is the full-range wrap.
  always_comb begin
    count_d = count_q;
    carry   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (up) begin
          if (count_q[k] == 4'd9) count_d[k] = 4'd0;
          else begin
            count_d[k] = count_q[k] + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (count_q[k] == 4'd0) count_d[k] = 4'd9;
          else begin
            count_d[k] = count_q[k] - 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

`ifdef SCAN_DISPLAY_LZ_BLANK_EN
  logic zero_above;
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (count_q[k] == 4'd0);
      blank[k]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  assign cur_dig = count_q[idx_q];
  assign cur_seg = blank[idx_q] ? 7'b1111111 : seg7(cur_dig);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      seg_an_q   <= '1;
      seg_cat_q  <= 8'hFF;
    end else begin
      wrap_q <= 1'b0;
      if (clr) begin
        count_q    <= '0;
        tick_cnt_q <= '0;
      end else if (tick) begin
        count_q    <= count_d;
        tick_cnt_q <= '0;
        wrap_q     <= carry;
      end else if (en) begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
      end
      // Scan keeps running independent of en/clr.
      if (scan_cnt_q == SW'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        idx_q      <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        scan_cnt_q <= scan_cnt_q + SW'(1);
      end
      seg_an_q  <= ~(DIGITS'(1) << idx_q);
      seg_cat_q <= {1'b1, cur_seg};
    end
  end
endmodule

// File: tb/tb_scan_display_ctrl.sv
// Scoreboard bench for scan_display_ctrl with DIGITS=4, SCAN_DIV=4, TICK_DIV=3.
module tb_scan_display_ctrl;
  localparam int DIGITS = 4, SCAN_DIV = 4, TICK_DIV = 3;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0, up = 1'b1, clr = 1'b0;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [3:0]  seg_an;
  logic [7:0]  seg_cat;

  int n_chk = 0, n_fail = 0;
  int exp_val = 0;
  logic [15:0] exp_q[$];
  logic [11:0] scan_q[$];

  scan_display_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr),
    .count_bcd(count_bcd), .wrap(wrap), .seg_an(seg_an), .seg_cat(seg_cat)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  function automatic logic [7:0] cat_of(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  default: return 8'h90;
    endcase
  endfunction

  // Runs n ticks from a zero divider phase and queues the resulting count.
  task automatic tick_n(input int n, input bit dir);
    en = 1'b1; up = dir;
    repeat (3 * n) @(negedge clk);
    en = 1'b0;
    exp_val = dir ? (exp_val + n) % 10000 : (exp_val + 10000 - (n % 10000)) % 10000;
    exp_q.push_back(to_bcd(exp_val));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_val = 0;
  endtask

  task automatic get_digit(input int k, output logic [7:0] cat, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << k);
    ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40 && !ok; i++) begin
      if (seg_an == want) ok = 1'b1;
      else @(negedge clk);
    end
    cat = seg_cat;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    repeat (2) @(negedge clk);
    n_chk++; if (count_bcd !== 16'h0000) begin n_fail++; $display("FAIL rst_count got %h want 0000", count_bcd); end
    n_chk++; if (seg_an !== 4'b1111 || seg_cat !== 8'hFF || wrap !== 1'b0) begin n_fail++; $display("FAIL rst_outs got an=%b cat=%h wrap=%b want 1111 FF 0", seg_an, seg_cat, wrap); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (seg_an !== 4'b1110) begin n_fail++; $display("FAIL rst_release_an got %b want 1110", seg_an); end
    tick_n(2, 1'b1);
    e = exp_q.pop_front();
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL pre_rst_count got %h want %h", count_bcd, e); end
    en = 1'b1; rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (count_bcd !== 16'h0000 || seg_an !== 4'b1111 || seg_cat !== 8'hFF) begin n_fail++; $display("FAIL midrst got cnt=%h an=%b cat=%h want 0000 1111 FF", count_bcd, seg_an, seg_cat); end
    rst = 1'b1; en = 1'b0; exp_val = 0;
    @(negedge clk);
    n_chk++; if (seg_an !== 4'b1110 || count_bcd !== 16'h0000) begin n_fail++; $display("FAIL midrst_release got an=%b cnt=%h want 1110 0000", seg_an, count_bcd); end
  endtask

  task automatic test_count_up();
    logic [15:0] e;
    logic [7:0] cat;
    bit ok;
    do_clr();
    tick_n(9, 1'b1);
    e = exp_q.pop_front();
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL up_to_9 got %h want %h", count_bcd, e); end
    tick_n(1, 1'b1);
    e = exp_q.pop_front();
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL up_carry got %h want %h", count_bcd, e); end
    get_digit(0, cat, ok);
    n_chk++; if (!ok || cat !== cat_of(0)) begin n_fail++; $display("FAIL up_dig0_cat got %h ok=%0d want %h", cat, ok, cat_of(0)); end
    get_digit(1, cat, ok);
    n_chk++; if (!ok || cat !== cat_of(1)) begin n_fail++; $display("FAIL up_dig1_cat got %h ok=%0d want %h", cat, ok, cat_of(1)); end
  endtask

  task automatic test_rollover();
    do_clr();
    en = 1'b1; up = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (count_bcd !== 16'h0000 || wrap !== 1'b0) begin n_fail++; $display("FAIL dn_pre got cnt=%h wrap=%b want 0000 0", count_bcd, wrap); end
    @(negedge clk);
    en = 1'b0; exp_val = 9999;
    n_chk++; if (count_bcd !== to_bcd(exp_val) || wrap !== 1'b1) begin n_fail++; $display("FAIL dn_wrap got cnt=%h wrap=%b want 9999 1", count_bcd, wrap); end
    @(negedge clk);
    n_chk++; if (wrap !== 1'b0 || count_bcd !== 16'h9999) begin n_fail++; $display("FAIL dn_wrap_len got wrap=%b cnt=%h want 0 9999", wrap, count_bcd); end
    en = 1'b1; up = 1'b1;
    repeat (3) @(negedge clk);
    en = 1'b0; exp_val = 0;
    n_chk++; if (count_bcd !== to_bcd(exp_val) || wrap !== 1'b1) begin n_fail++; $display("FAIL up_wrap got cnt=%h wrap=%b want 0000 1", count_bcd, wrap); end
    @(negedge clk);
    n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL up_wrap_len got wrap=%b want 0", wrap); end
  endtask

  task automatic test_clr_collision();
    logic [15:0] e;
    do_clr();
    tick_n(1, 1'b0);
    e = exp_q.pop_front();
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL clr_pre got %h want %h", count_bcd, e); end
    en = 1'b1; up = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0; en = 1'b0; exp_val = 0;
    n_chk++; if (count_bcd !== 16'h0000 || wrap !== 1'b0) begin n_fail++; $display("FAIL clr_vs_tick got cnt=%h wrap=%b want 0000 0", count_bcd, wrap); end
    @(negedge clk);
    n_chk++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL clr_wrap_after got %b want 0", wrap); end
  endtask

  task automatic test_freeze();
    logic [15:0] e;
    tick_n(5, 1'b1);
    e = exp_q.pop_front();
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL frz_pre got %h want %h", count_bcd, e); end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      up = 1'($urandom);
      @(negedge clk);
    end
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL frz_hold got %h want %h", count_bcd, e); end
    en = 1'b1; up = 1'b1;
    @(negedge clk);
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL frz_phase got %h want %h", count_bcd, e); end
    @(negedge clk);
    en = 1'b0; exp_val = exp_val + 1;
    n_chk++; if (count_bcd !== to_bcd(exp_val)) begin n_fail++; $display("FAIL frz_resume got %h want %h", count_bcd, to_bcd(exp_val)); end
  endtask

  task automatic test_scan();
    logic [15:0] e;
    logic [11:0] s;
    logic [3:0] prev;
    bit found;
    int digs[4] = '{4, 3, 2, 1};
    do_clr();
    tick_n(1234, 1'b1);
    e = exp_q.pop_front();
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL scan_count got %h want %h", count_bcd, e); end
    for (int sl = 0; sl < 5; sl++)
      for (int c = 0; c < 4; c++)
        scan_q.push_back({~(4'b0001 << (sl % 4)), cat_of(digs[sl % 4])});
    found = 1'b0;
    prev = seg_an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (seg_an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      prev = seg_an;
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL scan_sync got no slot0 start want 1110 within 40 cycles"); end
    for (int j = 0; j < 20; j++) begin
      s = scan_q.pop_front();
      n_chk++; if ({seg_an, seg_cat} !== s) begin n_fail++; $display("FAIL scan_cyc%0d got an=%b cat=%h want an=%b cat=%h", j, seg_an, seg_cat, s[11:8], s[7:0]); end
      if (j < 19) @(negedge clk);
    end
  endtask

  task automatic test_blank();
    logic [15:0] e;
    logic [7:0] cat, lz;
    bit ok;
`ifdef SCAN_DISPLAY_LZ_BLANK_EN
    lz = 8'hFF;
`else
    lz = 8'hC0;
`endif
    do_clr();
    tick_n(42, 1'b1);
    e = exp_q.pop_front();
    n_chk++; if (count_bcd !== e) begin n_fail++; $display("FAIL blank_count got %h want %h", count_bcd, e); end
    get_digit(3, cat, ok);
    n_chk++; if (!ok || cat !== lz) begin n_fail++; $display("FAIL blank_dig3 got %h ok=%0d want %h", cat, ok, lz); end
    get_digit(2, cat, ok);
    n_chk++; if (!ok || cat !== lz) begin n_fail++; $display("FAIL blank_dig2 got %h ok=%0d want %h", cat, ok, lz); end
    get_digit(1, cat, ok);
    n_chk++; if (!ok || cat !== cat_of(4)) begin n_fail++; $display("FAIL blank_dig1 got %h ok=%0d want %h", cat, ok, cat_of(4)); end
    get_digit(0, cat, ok);
    n_chk++; if (!ok || cat !== cat_of(2)) begin n_fail++; $display("FAIL blank_dig0 got %h ok=%0d want %h", cat, ok, cat_of(2)); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_up();
    test_rollover();
    test_clr_collision();
    test_freeze();
    test_scan();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
